// File: rtl/pipo_shift_engine.sv
// Parallel-in/parallel-out shift engine: loads a word, then performs one
// 1-bit shift/rotate step per clock until the requested distance is covered.
module pipo_shift_engine #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       load_en,
    input  logic                       start,
    input  logic [2:0]                 shift_mode,
    input  logic [$clog2(WIDTH)-1:0]   shift_amt,
    output logic [WIDTH-1:0]           data_out,
    output logic                       busy,
    output logic                       done,
    output logic                       carry_out,
    output logic                       overflow
);

    localparam int AMT_W = $clog2(WIDTH);

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASL = 3'b010;
    localparam logic [2:0] MODE_ASR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ROR = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Handshake: load_en/start are level requests sampled on any rising edge
    // while not busy; load wins over start; requests seen while busy are dropped.

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;

    logic [WIDTH-1:0]   step_data;
    logic               step_carry;
    logic               step_ovf;

    // One 1-bit step of the captured mode; reserved modes are a no-op.
    always_comb begin
        step_data  = data_q;
        step_carry = carry_q;
        step_ovf   = 1'b0;
        case (mode_q)
            MODE_LSL: begin
                step_data  = {data_q[WIDTH-2:0], 1'b0};
                step_carry = data_q[WIDTH-1];
            end
            MODE_ASL: begin
                step_data  = {data_q[WIDTH-2:0], 1'b0};
                step_carry = data_q[WIDTH-1];
                step_ovf   = data_q[WIDTH-1] ^ data_q[WIDTH-2];
            end
            MODE_LSR: begin
                step_data  = {1'b0, data_q[WIDTH-1:1]};
                step_carry = data_q[0];
            end
            MODE_ASR: begin
                step_data  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                step_carry = data_q[0];
            end
            MODE_ROL: begin
                step_data  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                step_carry = data_q[WIDTH-1];
            end
            MODE_ROR: begin
                step_data  = {data_q[0], data_q[WIDTH-1:1]};
                step_carry = data_q[0];
            end
            default: begin
                step_data  = data_q;
                step_carry = carry_q;
                step_ovf   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (load_en) begin
                    data_d  = data_in;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end else if (start) begin
                    mode_d  = shift_mode;
                    cnt_d   = shift_amt;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = (shift_amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_d  = step_data;
                carry_d = step_carry;
                ovf_d   = ovf_q | step_ovf;
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign data_out  = data_q;
    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipo_shift_engine.sv
// Bench for pipo_shift_engine (WIDTH=16): directed vector table, hand-written
// corner sequences and random operations against a whole-operation model.
module tb_pipo_shift_engine;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  data_in;
    logic          load_en;
    logic          start;
    logic [2:0]    shift_mode;
    logic [3:0]    shift_amt;
    logic [W-1:0]  data_out;
    logic          busy;
    logic          done;
    logic          carry_out;
    logic          overflow;

    pipo_shift_engine #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .load_en    (load_en),
        .start      (start),
        .shift_mode (shift_mode),
        .shift_amt  (shift_amt),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .carry_out  (carry_out),
        .overflow   (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic         exp_c_q[$];
    logic         exp_o_q[$];
    logic [W-1:0] m_data;

    typedef struct {
        logic [W-1:0] d;
        logic [2:0]   mode;
        int           amt;
        logic [W-1:0] exp_d;
        logic         exp_c;
        logic         exp_o;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Whole-operation reference: result of shifting by n in one go.
    task automatic ref_op(input logic [W-1:0] d, input logic [2:0] mode, input int n,
                          output logic [W-1:0] r, output logic c, output logic o);
        logic [31:0] top;
        logic [31:0] ones;
        r = d;
        c = 1'b0;
        o = 1'b0;
        case (mode)
            3'd0, 3'd2: begin
                r = d << n;
                if (n > 0) c = d[W-n];
                if (mode == 3'd2 && n > 0) begin
                    top  = 32'(d) >> (W - 1 - n);
                    ones = (32'd1 << (n + 1)) - 32'd1;
                    o    = !(top == 32'd0 || top == ones);
                end
            end
            3'd1: begin
                r = d >> n;
                if (n > 0) c = d[n-1];
            end
            3'd3: begin
                r = W'($signed(d) >>> n);
                if (n > 0) c = d[n-1];
            end
            3'd4: begin
                r = W'((32'(d) << n) | (32'(d) >> (W - n)));
                if (n > 0) c = d[W-n];
            end
            3'd5: begin
                r = W'((32'(d) >> n) | (32'(d) << (W - n)));
                if (n > 0) c = d[n-1];
            end
            default: begin
                r = d;
            end
        endcase
    endtask

    task automatic load_op(input logic [W-1:0] d);
        load_en = 1'b1;
        data_in = d;
        tick();
        load_en = 1'b0;
        m_data  = d;
        check("load_data", data_out, d);
        check("load_flags", {carry_out, overflow, busy, done}, 4'b0);
    endtask

    task automatic start_op(input logic [2:0] mode, input int amt);
        logic [W-1:0] r;
        logic         c;
        logic         o;
        ref_op(m_data, mode, amt, r, c, o);
        exp_q.push_back(r);
        exp_c_q.push_back(c);
        exp_o_q.push_back(o);
        start      = 1'b1;
        shift_mode = mode;
        shift_amt  = 4'(amt);
        tick();
        start      = 1'b0;
    endtask

    // Waits for done (bounded), checks latency and result; optionally jams
    // requests onto the inputs for the first two SHIFT cycles.
    task automatic wait_done(input int amt, input bit disturb, input bit final_tick);
        int cyc;
        int nb;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        cyc = 0;
        nb  = 0;
        while (!done && cyc < 64) begin
            if (busy) nb++;
            if (disturb && cyc < 2) begin
                load_en    = 1'b1;
                start      = 1'b1;
                data_in    = W'($urandom);
                shift_mode = 3'($urandom);
                shift_amt  = 4'($urandom);
            end else begin
                load_en = 1'b0;
                start   = 1'b0;
            end
            tick();
            cyc++;
        end
        load_en = 1'b0;
        start   = 1'b0;
        check("done_latency", cyc, amt);
        check("busy_cycles", nb, amt);
        r = exp_q.pop_front();
        c = exp_c_q.pop_front();
        o = exp_o_q.pop_front();
        check("result_data", data_out, r);
        check("result_carry", carry_out, c);
        check("result_ovf", overflow, o);
        m_data = r;
        if (final_tick) begin
            tick();
            check("done_width", {busy, done}, 2'b00);
            check("hold_data", data_out, r);
            check("hold_flags", {carry_out, overflow}, {c, o});
        end
    endtask

    initial begin
        int dcnt;
        n_checks   = 0;
        n_fail     = 0;
        m_data     = '0;
        rst_n      = 1'b0;
        data_in    = '0;
        load_en    = 1'b0;
        start      = 1'b0;
        shift_mode = '0;
        shift_amt  = '0;

        vecs[0] = '{16'h8E16, 3'd0, 3, 16'h70B0, 1'b0, 1'b0};
        vecs[1] = '{16'hF0F0, 3'd3, 4, 16'hFF0F, 1'b0, 1'b0};
        vecs[2] = '{16'h8E16, 3'd5, 4, 16'h68E1, 1'b0, 1'b0};
        vecs[3] = '{16'h4000, 3'd2, 1, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8E16, 3'd4, 1, 16'h1C2D, 1'b1, 1'b0};
        vecs[5] = '{16'h8E16, 3'd6, 5, 16'h8E16, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {data_out, busy, done, carry_out, overflow}, 20'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 6; i++) begin
            load_op(vecs[i].d);
            start_op(vecs[i].mode, vecs[i].amt);
            wait_done(vecs[i].amt, 1'b0, 1'b0);
            check("vec_data", data_out, vecs[i].exp_d);
            check("vec_carry", carry_out, vecs[i].exp_c);
            check("vec_ovf", overflow, vecs[i].exp_o);
            tick();
        end

        // load and start on the same edge: load only
        data_in    = 16'h1234;
        load_en    = 1'b1;
        start      = 1'b1;
        shift_mode = 3'd4;
        shift_amt  = 4'd5;
        tick();
        load_en = 1'b0;
        start   = 1'b0;
        m_data  = 16'h1234;
        check("prio_data", data_out, 16'h1234);
        check("prio_busy", {busy, done}, 2'b00);
        tick();
        check("prio_busy2", {busy, done}, 2'b00);

        // zero-distance start
        start_op(3'd0, 0);
        wait_done(0, 1'b0, 1'b1);

        // requests during SHIFT are ignored
        load_op(16'hAAA5);
        start_op(3'd4, 6);
        wait_done(6, 1'b1, 1'b1);

        // back-to-back: start accepted in the DONE cycle
        load_op(16'h2001);
        start_op(3'd2, 2);
        wait_done(2, 1'b0, 1'b0);
        start_op(3'd1, 3);
        check("b2b_busy", busy, 1'b1);
        check("b2b_ovf_clear", overflow, 1'b0);
        wait_done(3, 1'b0, 1'b1);

        // reset during the second SHIFT cycle
        load_op(16'h8E16);
        start_op(3'd0, 5);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {data_out, busy, done, carry_out, overflow}, 20'h0);
        void'(exp_q.pop_back());
        void'(exp_c_q.pop_back());
        void'(exp_o_q.pop_back());
        m_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt  = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (done) dcnt++;
            @(negedge clk);
        end
        check("midrst_no_done", dcnt, 0);
        load_op(16'hABCD);

        // random operations against the model
        for (int i = 0; i < 40; i++) begin
            int amt;
            logic [2:0] mode;
            amt  = $urandom_range(0, 15);
            mode = 3'($urandom_range(0, 7));
            load_op(W'($urandom));
            start_op(mode, amt);
            wait_done(amt, ($urandom_range(0, 3) == 0) && amt >= 3, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipo_shift_engine.md
PIPO_SHIFT_ENGINE -- requirements
Module: pipo_shift_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data width in bits, legal range 2..64.
REQ-002 The block SHALL derive local constant AMT_W = clog2(WIDTH); it SHALL NOT be overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  WIDTH  parallel load data.
REQ-006 load_en  input  1  parallel load request.
REQ-007 start  input  1  shift operation request.
REQ-008 shift_mode  input  3  000 LSL, 001 LSR, 010 ASL, 011 ASR, 100 ROL, 101 ROR, 110/111 reserved.
REQ-009 shift_amt  input  AMT_W  shift distance in bits, 0..WIDTH-1.
REQ-010 data_out  output  WIDTH  shift register contents, registered.
REQ-011 busy  output  1  high while a multi-cycle shift is in progress.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 carry_out  output  1  last bit shifted or rotated out.
REQ-014 overflow  output  1  sticky ASL sign-change flag.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE; busy = (state==SHIFT) and done = (state==DONE), both decoded from registered state.
REQ-016 In IDLE or DONE, load_en=1 SHALL load data_in into data_out and clear carry_out and overflow at the edge; next state SHALL be IDLE.
REQ-017 In IDLE or DONE, start=1 with load_en=0 SHALL capture shift_mode and shift_amt and clear carry_out and overflow; next state SHALL be SHIFT if shift_amt!=0, else DONE.
REQ-018 If load_en and start are both high in IDLE or DONE, load SHALL win and start SHALL be dropped.
REQ-019 In SHIFT, each edge SHALL perform exactly one 1-bit step in the captured mode and decrement the remaining count; the edge performing the final step SHALL move to DONE.
REQ-020 In SHIFT, load_en, start, shift_mode and shift_amt SHALL be ignored.
REQ-021 DONE SHALL last one cycle and return to IDLE unless a new load or start is accepted in that cycle.
REQ-022 Latency: with start sampled at edge E0 and N=shift_amt, busy SHALL be high for N cycles and done SHALL be high during the cycle following edge E0+N.
REQ-023 LSL/ASL SHALL shift in 0 at bit 0; LSR SHALL shift in 0 at MSB; ASR SHALL replicate MSB; ROL/ROR SHALL rotate with no bit loss.
REQ-024 carry_out SHALL take, per step, the MSB before the step for LSL/ASL/ROL and the LSB before the step for LSR/ASR/ROR.
REQ-025 overflow SHALL set in ASL when a step changes the MSB, and SHALL remain set until the next accepted load or start.
REQ-026 Reserved modes SHALL leave data_out, carry_out and overflow unchanged while still sequencing through SHIFT for N cycles and then to DONE.
REQ-027 data_out SHALL be held unchanged in IDLE and DONE absent a load.

Reset
REQ-028 While rst_n=0, state SHALL be IDLE, data_out=0, busy=0, done=0, carry_out=0, overflow=0, and the internal count and captured mode SHALL be 0, regardless of the clock.
REQ-029 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; after release, the block SHALL accept operations on the first edge.

Verification
REQ-030 Reset mid-shift: WIDTH=16, assert rst_n=0 during the second SHIFT cycle -> all outputs 0 immediately (before the next clock edge), no done pulse after release.
REQ-031 LSL: load 16'h8E16, start mode 000 amt 3 -> busy high 3 cycles, then done high 1 cycle, data_out=16'h70B0, carry_out=0.
REQ-032 ASR: load 16'hF0F0, start mode 011 amt 4 -> data_out=16'hFF0F, carry_out=0, done in the cycle after edge E0+4.
REQ-033 ROR: load 16'h8E16, mode 101 amt 4 -> data_out=16'h68E1, carry_out=0; ASL: load 16'h4000, mode 010 amt 1 -> data_out=16'h8000, overflow=1, carry_out=0.
REQ-034 Priority and edges: load_en+start same edge -> load only, busy stays 0; start amt 0 -> done in next cycle, data unchanged; start and load_en pulsed during SHIFT -> ignored, result as if absent.
REQ-035 Back-to-back: start accepted in the DONE cycle -> no IDLE cycle between operations, second result correct, overflow cleared at second start.
